mem_wb_hilo: RTL and testbench
==============================

// Module: mem_wb_hilo
// PURPOSE
//  MEM->WB pipeline register of the 5-stage MIPS core, merged with the architectural HI/LO register pair.
//  Captures the MEM stage's GPR and HI/LO write-back bundle each cycle, honouring stall and flush.
//  Presents the WB bundle to the regfile write port and commits HI/LO one cycle after WB.
//  Gives EX a forwarded HI/LO read: WB-stage pending write first, committed HI/LO otherwise.
// PARAMETERS
//  DATA_W    32  GPR / HI / LO data width
//  ADDR_W    5   GPR address width
//  NOP_ADDR  0   GPR address driven when the stage holds a bubble
// PORTS
//  clk             in   1       rising-edge clock
//  rst             in   1       reset; synchronous, active-high
//  mem_stall       in   1       MEM stage stalled this cycle
//  wb_stall        in   1       WB stage stalled this cycle
//  flush           in   1       exception/redirect flush of the WB register
//  mem_wdata_i     in   DATA_W  GPR write data from MEM
//  mem_waddr_i     in   ADDR_W  GPR write address from MEM
//  mem_wen_i       in   1       GPR write enable from MEM
//  mem_hi_i        in   DATA_W  HI write data from MEM
//  mem_lo_i        in   DATA_W  LO write data from MEM
//  mem_hilo_wen_i  in   1       HI/LO write enable from MEM
//  wb_wdata_o      out  DATA_W  GPR write data to regfile
//  wb_waddr_o      out  ADDR_W  GPR write address to regfile
//  wb_wen_o        out  1       GPR write enable to regfile
//  wb_hi_o         out  DATA_W  WB-stage HI data (forwarding source)
//  wb_lo_o         out  DATA_W  WB-stage LO data (forwarding source)
//  wb_hilo_wen_o   out  1       WB-stage HI/LO write enable
//  hi_o            out  DATA_W  committed HI
//  lo_o            out  DATA_W  committed LO
//  hi_fwd_o        out  DATA_W  wb_hilo_wen_o ? wb_hi_o : hi_o (combinational)
//  lo_fwd_o        out  DATA_W  wb_hilo_wen_o ? wb_lo_o : lo_o (combinational)
// BEHAVIOUR
//  - Reset: all registered outputs 0, wb_waddr_o=NOP_ADDR, wb_wen_o=0, wb_hilo_wen_o=0, hi_o=lo_o=0.
//  - rst takes priority over every other input at the edge.
//  - WB register update per edge, in priority order:
//     1. rst                       -> reset values.
//     2. flush                     -> bubble (wen=0, hilo_wen=0, addr=NOP_ADDR, data=0); wins over stalls.
//     3. mem_stall & !wb_stall     -> bubble inserted (same values as flush).
//     4. wb_stall                  -> hold all WB outputs unchanged.
//     5. otherwise                 -> capture all mem_*_i; latency MEM->WB outputs = 1 cycle.
//  - HI/LO commit: at each edge, if wb_hilo_wen_o=1 and !wb_stall then hi_o<=wb_hi_o, lo_o<=wb_lo_o.
//    Commit is 1 cycle after the bundle enters WB (2 cycles after MEM presents it).
//    Commit uses current WB contents, so a simultaneous flush does not cancel an already-in-WB write.
//  - Stalled WB holds wb_hilo_wen_o and does not commit; commit happens once on the releasing edge.
//  - Forwarding muxes are purely combinational; no added cycle. Back-to-back MTHI/MTLO in MEM then WB:
//    hi_fwd_o always reflects the youngest value (in WB) before commit.
//  - GPR write and HI/LO write in the same bundle are independent; both propagate.
//  - No arithmetic; widths pass through unchanged. No combinational path from mem_*_i to any output.
// TESTING
//  1. rst=1 two cycles, inputs random -> all outputs 0, wb_waddr_o=0, hi_o=lo_o=0; then rst=0 clean.
//  2. MEM wdata=0x1234_5678, waddr=5, wen=1, no stall -> next cycle wb_wdata_o=0x12345678, wb_waddr_o=5, wb_wen_o=1.
//  3. MEM hi=0xAAAA_0001, lo=0xBBBB_0002, hilo_wen=1 -> cycle+1 hi_fwd_o=0xAAAA0001 (hi_o still 0);
//     cycle+2 hi_o=0xAAAA0001, lo_o=0xBBBB0002.
//  4. mem_stall=1, wb_stall=0 with wen=1 bundle at input -> WB shows bubble (wen=0, addr=0); hi_o unchanged.
//  5. wb_stall=1 for 3 cycles holding hilo_wen bundle hi=0x7 -> outputs frozen, hi_o unchanged; release -> hi_o=0x7 next edge, exactly once.
//  6. flush=1 together with mem_stall=1, wb_stall=1 -> bubble next cycle; rst asserted mid-stall -> reset values next cycle.

Source files
------------

// File: rtl/mem_wb_hilo.sv
// MEM->WB pipeline register merged with the architectural HI/LO pair.
// HI/LO commit one edge after a bundle reaches WB; EX reads HI/LO through a WB-first forward mux.
module mem_wb_hilo #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NOP_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_stall,
  input  logic              wb_stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic [ADDR_W-1:0] mem_waddr_i,
  input  logic              mem_wen_i,
  input  logic [DATA_W-1:0] mem_hi_i,
  input  logic [DATA_W-1:0] mem_lo_i,
  input  logic              mem_hilo_wen_i,
  output logic [DATA_W-1:0] wb_wdata_o,
  output logic [ADDR_W-1:0] wb_waddr_o,
  output logic              wb_wen_o,
  output logic [DATA_W-1:0] wb_hi_o,
  output logic [DATA_W-1:0] wb_lo_o,
  output logic              wb_hilo_wen_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic [DATA_W-1:0] hi_fwd_o,
  output logic [DATA_W-1:0] lo_fwd_o
);

  localparam logic [ADDR_W-1:0] NopAddr = ADDR_W'(NOP_ADDR);

  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] whi_q, whi_d;
  logic [DATA_W-1:0] wlo_q, wlo_d;
  logic              hilo_wen_q, hilo_wen_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              bubble;

  // Flush beats both stalls; a MEM stall with a free WB drains into a bubble.
  assign bubble = flush | (mem_stall & ~wb_stall);

  always_comb begin
    wdata_d    = wdata_q;
    waddr_d    = waddr_q;
    wen_d      = wen_q;
    whi_d      = whi_q;
    wlo_d      = wlo_q;
    hilo_wen_d = hilo_wen_q;
    if (bubble) begin
      wdata_d    = '0;
      waddr_d    = NopAddr;
      wen_d      = 1'b0;
      whi_d      = '0;
      wlo_d      = '0;
      hilo_wen_d = 1'b0;
    end else if (!wb_stall) begin
      wdata_d    = mem_wdata_i;
      waddr_d    = mem_waddr_i;
      wen_d      = mem_wen_i;
      whi_d      = mem_hi_i;
      wlo_d      = mem_lo_i;
      hilo_wen_d = mem_hilo_wen_i;
    end
  end

  // Commit uses current WB contents, so a concurrent flush cannot cancel it.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (hilo_wen_q && !wb_stall) begin
      hi_d = whi_q;
      lo_d = wlo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdata_q    <= '0;
      waddr_q    <= NopAddr;
      wen_q      <= 1'b0;
      whi_q      <= '0;
      wlo_q      <= '0;
      hilo_wen_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      wdata_q    <= wdata_d;
      waddr_q    <= waddr_d;
      wen_q      <= wen_d;
      whi_q      <= whi_d;
      wlo_q      <= wlo_d;
      hilo_wen_q <= hilo_wen_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign wb_wdata_o    = wdata_q;
  assign wb_waddr_o    = waddr_q;
  assign wb_wen_o      = wen_q;
  assign wb_hi_o       = whi_q;
  assign wb_lo_o       = wlo_q;
  assign wb_hilo_wen_o = hilo_wen_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign hi_fwd_o      = hilo_wen_q ? whi_q : hi_q;
  assign lo_fwd_o      = hilo_wen_q ? wlo_q : lo_q;

endmodule

// File: tb/tb_mem_wb_hilo.sv
// Bench for mem_wb_hilo: directed scenarios then random traffic, all against a bundle-level model.
module tb_mem_wb_hilo;

  logic        clk = 1'b0;
  logic        rst, mem_stall, wb_stall, flush;
  logic [31:0] mem_wdata_i, mem_hi_i, mem_lo_i;
  logic [4:0]  mem_waddr_i;
  logic        mem_wen_i, mem_hilo_wen_i;
  logic [31:0] wb_wdata_o, wb_hi_o, wb_lo_o, hi_o, lo_o, hi_fwd_o, lo_fwd_o;
  logic [4:0]  wb_waddr_o;
  logic        wb_wen_o, wb_hilo_wen_o;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  mem_wb_hilo dut (
    .clk           (clk),
    .rst           (rst),
    .mem_stall     (mem_stall),
    .wb_stall      (wb_stall),
    .flush         (flush),
    .mem_wdata_i   (mem_wdata_i),
    .mem_waddr_i   (mem_waddr_i),
    .mem_wen_i     (mem_wen_i),
    .mem_hi_i      (mem_hi_i),
    .mem_lo_i      (mem_lo_i),
    .mem_hilo_wen_i(mem_hilo_wen_i),
    .wb_wdata_o    (wb_wdata_o),
    .wb_waddr_o    (wb_waddr_o),
    .wb_wen_o      (wb_wen_o),
    .wb_hi_o       (wb_hi_o),
    .wb_lo_o       (wb_lo_o),
    .wb_hilo_wen_o (wb_hilo_wen_o),
    .hi_o          (hi_o),
    .lo_o          (lo_o),
    .hi_fwd_o      (hi_fwd_o),
    .lo_fwd_o      (lo_fwd_o)
  );

  typedef struct {
    logic [31:0] wdata;
    logic [4:0]  waddr;
    logic        wen;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        hilo_wen;
  } bundle_t;

  bundle_t     m_wb;
  bundle_t     nop;
  logic [31:0] m_hi, m_lo;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("wb_wdata", wb_wdata_o, m_wb.wdata);
    check("wb_waddr", 32'(wb_waddr_o), 32'(m_wb.waddr));
    check("wb_wen", 32'(wb_wen_o), 32'(m_wb.wen));
    check("wb_hi", wb_hi_o, m_wb.hi);
    check("wb_lo", wb_lo_o, m_wb.lo);
    check("wb_hilo_wen", 32'(wb_hilo_wen_o), 32'(m_wb.hilo_wen));
    check("hi", hi_o, m_hi);
    check("lo", lo_o, m_lo);
    check("hi_fwd", hi_fwd_o, m_wb.hilo_wen ? m_wb.hi : m_hi);
    check("lo_fwd", lo_fwd_o, m_wb.hilo_wen ? m_wb.lo : m_lo);
  endtask

  // Drive one cycle of inputs (called at negedge), advance model at the edge, check at next negedge.
  task automatic step(input logic r, input logic ms, input logic ws, input logic fl,
                      input logic [31:0] wd, input logic [4:0] wa, input logic we,
                      input logic [31:0] h, input logic [31:0] l, input logic hw);
    bundle_t in;
    rst = r; mem_stall = ms; wb_stall = ws; flush = fl;
    mem_wdata_i = wd; mem_waddr_i = wa; mem_wen_i = we;
    mem_hi_i = h; mem_lo_i = l; mem_hilo_wen_i = hw;
    in = '{wdata: wd, waddr: wa, wen: we, hi: h, lo: l, hilo_wen: hw};
    @(posedge clk);
    if (r) begin
      m_wb = nop; m_hi = 0; m_lo = 0;
    end else begin
      if (m_wb.hilo_wen && !ws) begin
        m_hi = m_wb.hi; m_lo = m_wb.lo;
      end
      if (fl || (ms && !ws)) m_wb = nop;
      else if (!ws)          m_wb = in;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    nop = '{wdata: 0, waddr: 0, wen: 0, hi: 0, lo: 0, hilo_wen: 0};
    m_wb = nop; m_hi = 0; m_lo = 0;
    @(negedge clk);

    // Reset with random inputs
    for (int i = 0; i < 2; i++)
      step(1, $urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom, 5'($urandom),
           $urandom_range(1), $urandom, $urandom, $urandom_range(1));
    check("rst_waddr", 32'(wb_waddr_o), 0);
    check("rst_hi", hi_o, 0);

    // GPR capture, one-cycle latency
    step(0, 0, 0, 0, 32'h1234_5678, 5, 1, 0, 0, 0);
    check("gpr_wdata", wb_wdata_o, 32'h1234_5678);
    check("gpr_waddr", 32'(wb_waddr_o), 5);

    // HI/LO forwarded at +1, committed at +2
    step(0, 0, 0, 0, 0, 0, 0, 32'hAAAA_0001, 32'hBBBB_0002, 1);
    check("fwd_hi_early", hi_fwd_o, 32'hAAAA_0001);
    check("hi_not_yet", hi_o, 0);
    idle();
    check("hi_commit", hi_o, 32'hAAAA_0001);
    check("lo_commit", lo_o, 32'hBBBB_0002);

    // MEM stall with free WB inserts a bubble
    step(0, 1, 0, 0, 32'hDEAD_BEEF, 7, 1, 32'h55, 32'h66, 1);
    check("bubble_wen", 32'(wb_wen_o), 0);
    check("bubble_hi", hi_o, 32'hAAAA_0001);

    // WB stall holds a pending HI/LO write; commit once on release
    step(0, 0, 0, 0, 0, 0, 0, 32'h7, 32'h8, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, $urandom, 5'($urandom), 1, $urandom, $urandom, 1);
      check("stall_hi_held", hi_o, 32'hAAAA_0001);
    end
    idle();
    check("release_hi", hi_o, 32'h7);
    step(0, 0, 0, 0, 0, 0, 0, 32'h99, 32'h98, 1);
    idle();

    // Flush beats both stalls; rst mid-stall
    step(0, 0, 0, 0, 32'h42, 3, 1, 32'h11, 32'h22, 1);
    step(0, 1, 1, 1, 32'h43, 4, 1, 32'h33, 32'h44, 1);
    check("flush_wen", 32'(wb_wen_o), 0);
    step(0, 0, 0, 0, 32'h45, 6, 1, 32'h77, 32'h88, 1);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("rst_mid_hi", hi_o, 0);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(49) == 0), ($urandom_range(3) == 0), ($urandom_range(3) == 0),
           ($urandom_range(9) == 0), $urandom, 5'($urandom), $urandom_range(1),
           $urandom, $urandom, $urandom_range(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
